// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-controller bundle: pipeline register addresses/enables in, forward/stall/flush controls out.
interface hazard_ctrl_mc_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [REG_AW-1:0] RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              LoadE, PCSrcE, McOpE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              McBusy, McStart;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, McOpE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, McBusy, McStart
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, McOpE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, McBusy, McStart
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Forwarding, load-use/RAW stall, branch flush and multi-cycle execute hold
// for the 5-stage pipeline. Control outputs are combinational from inputs and state.
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 3,
  parameter bit          FWD_EN     = 1'b1
) (
  input logic            clk,
  input logic            reset,
  hazard_ctrl_mc_if.slave hz
);

  localparam bit MC_EN = (MC_LATENCY > 1);
  // Number of BUSY cycles after the start cycle; total hold is MC_LATENCY-1.
  localparam int unsigned BUSY_CYC_I = (MC_LATENCY > 2) ? (MC_LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] BUSY_CYC = CNT_W'(BUSY_CYC_I);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       mc_start, in_busy, held;
  logic       load_use, raw_dep, dep_stall, pc_take;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m == rs) && (rs != '0))      sel = 2'b10;
    else if (we_w && (rd_w == rs) && (rs != '0)) sel = 2'b01;
    return sel;
  endfunction

  function automatic logic d_dep(input logic [REG_AW-1:0] rd, input logic we,
                                 input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
    return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts remaining BUSY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mc_start) begin
          cnt_d   = BUSY_CYC;
          state_d = (BUSY_CYC == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mc_start  = MC_EN && (state_q == IDLE) && hz.McOpE;
    in_busy   = (state_q == BUSY);
    held      = mc_start || in_busy;
    load_use  = d_dep(hz.RdE, hz.LoadE, hz.Rs1D, hz.Rs2D);
    raw_dep   = !FWD_EN && (d_dep(hz.RdE, hz.RegWriteE, hz.Rs1D, hz.Rs2D) ||
                            d_dep(hz.RdM, hz.RegWriteM, hz.Rs1D, hz.Rs2D) ||
                            d_dep(hz.RdW, hz.RegWriteW, hz.Rs1D, hz.Rs2D));
    dep_stall = (load_use || raw_dep) && !held;
    pc_take   = hz.PCSrcE && !in_busy;
    fwd_a     = FWD_EN ? fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW) : 2'b00;
    fwd_b     = FWD_EN ? fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW) : 2'b00;
  end

  // Reset forces a drained, flushing pipeline regardless of inputs.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    hz.FlushM    = 1'b1;
    hz.McBusy    = 1'b0;
    hz.McStart   = 1'b0;
    if (!reset) begin
      hz.ForwardAE = fwd_a;
      hz.ForwardBE = fwd_b;
      hz.StallF    = held || (dep_stall && !pc_take);
      hz.StallD    = held || (dep_stall && !pc_take);
      hz.StallE    = held;
      hz.FlushD    = pc_take;
      hz.FlushE    = pc_take || dep_stall;
      hz.FlushM    = held;
      hz.McBusy    = (state_q != IDLE);
      hz.McStart   = mc_start;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: a forwarding/latency-4 build and a no-forwarding/latency-1
// build driven in lockstep, checked against a cycle-count reference model.
module tb_hazard_ctrl_mc;

  logic clk;
  logic rst;

  hazard_ctrl_mc_if #(.REG_AW(5)) hif_a ();
  hazard_ctrl_mc_if #(.REG_AW(5)) hif_b ();

  hazard_ctrl_mc #(.REG_AW(5), .MC_LATENCY(4), .CNT_W(3), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .reset(rst), .hz(hif_a));
  hazard_ctrl_mc #(.REG_AW(5), .MC_LATENCY(1), .CNT_W(1), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .reset(rst), .hz(hif_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwe, rwm, rww, loade, pcsrc, mcop;

  // Model state: BUSY cycles still to run, and whether the completion cycle is next.
  int hr_a = 0, hr_b = 0;
  bit dn_a = 0, dn_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic apply();
    hif_a.Rs1D = rs1d; hif_a.Rs2D = rs2d; hif_a.Rs1E = rs1e; hif_a.Rs2E = rs2e;
    hif_a.RdE = rde; hif_a.RdM = rdm; hif_a.RdW = rdw;
    hif_a.RegWriteE = rwe; hif_a.RegWriteM = rwm; hif_a.RegWriteW = rww;
    hif_a.LoadE = loade; hif_a.PCSrcE = pcsrc; hif_a.McOpE = mcop;
    hif_b.Rs1D = rs1d; hif_b.Rs2D = rs2d; hif_b.Rs1E = rs1e; hif_b.Rs2E = rs2e;
    hif_b.RdE = rde; hif_b.RdM = rdm; hif_b.RdW = rdw;
    hif_b.RegWriteE = rwe; hif_b.RegWriteM = rwm; hif_b.RegWriteW = rww;
    hif_b.LoadE = loade; hif_b.PCSrcE = pcsrc; hif_b.McOpE = mcop;
  endtask

  task automatic quiet();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    rwe = 0; rwm = 0; rww = 0; loade = 0; pcsrc = 0; mcop = 0;
  endtask

  function automatic bit uses_d(input logic [4:0] rd, input logic we);
    return we && (rd != 0) && (rd == rs1d || rd == rs2d);
  endfunction

  function automatic logic [1:0] fwd(input bit en, input logic [4:0] rs);
    if (!en || rs == 0) return 2'd0;
    if (rwm && rdm == rs) return 2'd2;
    if (rww && rdw == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Packed order: {FA[1:0],FB[1:0],StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy,McStart}
  function automatic logic [11:0] model(input bit en, input int lat, input int hr, input bit dn);
    bit busy, start, held, ds, pc, sf;
    if (rst) return 12'b0000_000_111_00;
    busy  = (hr > 0);
    start = !busy && !dn && mcop && (lat > 1);
    held  = busy || start;
    ds    = (uses_d(rde, loade) ||
             (!en && (uses_d(rde, rwe) || uses_d(rdm, rwm) || uses_d(rdw, rww)))) && !held;
    pc    = pcsrc && !busy;
    sf    = held || (ds && !pc);
    return {fwd(en, rs1e), fwd(en, rs2e), sf, sf, held, pc, pc || ds, held, busy || dn, start};
  endfunction

  task automatic upd(input int lat, inout int hr, inout bit dn);
    if (rst) begin
      hr = 0; dn = 0;
    end else if (hr > 0) begin
      hr = hr - 1;
      if (hr == 0) dn = 1;
    end else if (dn) begin
      dn = 0;
    end else if (mcop && lat > 1) begin
      if (lat > 2) hr = lat - 2;
      else dn = 1;
    end
  endtask

  function automatic logic [11:0] pack_a();
    return {hif_a.ForwardAE, hif_a.ForwardBE, hif_a.StallF, hif_a.StallD, hif_a.StallE,
            hif_a.FlushD, hif_a.FlushE, hif_a.FlushM, hif_a.McBusy, hif_a.McStart};
  endfunction

  function automatic logic [11:0] pack_b();
    return {hif_b.ForwardAE, hif_b.ForwardBE, hif_b.StallF, hif_b.StallD, hif_b.StallE,
            hif_b.FlushD, hif_b.FlushE, hif_b.FlushM, hif_b.McBusy, hif_b.McStart};
  endfunction

  // Drive inputs, let them settle mid-cycle, compare both builds with the model.
  task automatic settle(input string tag);
    apply();
    #4;
    check({tag, "_a"}, 32'(pack_a()), 32'(model(1'b1, 4, hr_a, dn_a)));
    check({tag, "_b"}, 32'(pack_b()), 32'(model(1'b0, 1, hr_b, dn_b)));
  endtask

  task automatic advance();
    upd(4, hr_a, dn_a);
    upd(1, hr_b, dn_b);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_stall;
  logic [3:0] exp_start;

  initial begin
    quiet();
    rst = 1'b1;
    apply();
    @(posedge clk);
    #1;
    settle("reset");
    check("reset_flushM", 32'(hif_a.FlushM), 32'd1);
    advance();
    rst = 1'b0;

    // Forward from M beats W.
    rs1e = 5; rdm = 5; rwm = 1; rdw = 5; rww = 1;
    settle("t1");
    check("t1_fwdA", 32'(hif_a.ForwardAE), 32'd2);
    advance();

    // Load-use one stall, then the load forwards from W.
    quiet(); loade = 1; rde = 6; rwe = 1; rs2d = 6;
    settle("t2_stall");
    check("t2_stallF", 32'(hif_a.StallF), 32'd1);
    check("t2_flushE", 32'(hif_a.FlushE), 32'd1);
    advance();
    quiet(); rs2e = 6; rdw = 6; rww = 1;
    settle("t2_fwd");
    check("t2_fwdB", 32'(hif_a.ForwardBE), 32'd1);
    advance();

    // x0 never forwarded; taken branch overrides load-use.
    quiet(); rs1e = 0; rdm = 0; rwm = 1;
    settle("t3_x0");
    check("t3_fwdA", 32'(hif_a.ForwardAE), 32'd0);
    advance();
    quiet(); loade = 1; rde = 3; rwe = 1; rs1d = 3; pcsrc = 1;
    settle("t3_pc");
    check("t3_stallF", 32'(hif_a.StallF), 32'd0);
    check("t3_flushD", 32'(hif_a.FlushD), 32'd1);
    advance();

    // Multi-cycle op held in E for four cycles.
    quiet(); mcop = 1;
    exp_stall = 4'b0111;
    exp_start = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      settle("t4");
      check("t4_stallE", 32'(hif_a.StallE), 32'(exp_stall[i]));
      check("t4_start", 32'(hif_a.McStart), 32'(exp_start[i]));
      check("t4_b_start", 32'(hif_b.McStart), 32'd0);
      advance();
    end
    mcop = 0;
    settle("t4_idle");
    check("t4_idle_busy", 32'(hif_a.McBusy), 32'd0);
    advance();

    // Reset in the second BUSY cycle, then restart.
    mcop = 1;
    settle("t5_start"); advance();
    settle("t5_busy1"); advance();
    rst = 1;
    settle("t5_rst");
    check("t5_rst_stallF", 32'(hif_a.StallF), 32'd0);
    advance();
    rst = 0; mcop = 0;
    settle("t5_after");
    check("t5_after_busy", 32'(hif_a.McBusy), 32'd0);
    advance();
    mcop = 1;
    settle("t5_restart");
    check("t5_restart_start", 32'(hif_a.McStart), 32'd1);
    advance();
    mcop = 0;
    for (int i = 0; i < 3; i++) begin
      settle("t5_drain"); advance();
    end

    // Without forwarding, an M dependence in D stalls.
    quiet(); rdm = 7; rwm = 1; rs1d = 7;
    settle("t6");
    check("t6_b_stallD", 32'(hif_b.StallD), 32'd1);
    check("t6_a_stallD", 32'(hif_a.StallD), 32'd0);
    advance();

    for (int n = 0; n < 3000; n++) begin
      rs1d = 5'($urandom_range(3)); rs2d = 5'($urandom_range(3));
      rs1e = 5'($urandom_range(3)); rs2e = 5'($urandom_range(3));
      rde  = 5'($urandom_range(3)); rdm  = 5'($urandom_range(3));
      rdw  = 5'($urandom_range(3));
      rwe  = 1'($urandom_range(1)); rwm = 1'($urandom_range(1)); rww = 1'($urandom_range(1));
      mcop = ($urandom_range(5) == 0);
      loade = mcop ? 1'b0 : ($urandom_range(3) == 0);
      pcsrc = mcop ? 1'b0 : ($urandom_range(5) == 0);
      rst   = ($urandom_range(79) == 0);
      settle("rand");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
